// File: rtl/servix_uart_monitor_if.sv
// Decoded-byte stream and status of the UART monitor.
// The monitor drives through master; the consumer reads through slave.
interface servix_uart_monitor_if #(
  parameter int unsigned FIFO_DEPTH = 16
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    o_rdt;
  logic          o_vld;
  logic          i_rdy;
  logic [LW-1:0] o_level;
  logic          o_frame_err;
  logic          o_overflow;
  logic          i_clr;

  modport master (
    output o_rdt, o_vld, o_level, o_frame_err, o_overflow,
    input  i_rdy, i_clr
  );

  modport slave (
    input  o_rdt, o_vld, o_level, o_frame_err, o_overflow,
    output i_rdy, i_clr
  );
endinterface

// File: rtl/servix_uart_monitor.sv
// 8N1 UART receiver on the servant q line.
// It buffers decoded bytes in a first-word-fall-through FIFO with a valid/ready read side.
module servix_uart_monitor #(
  parameter int unsigned CLKS_PER_BIT = 139,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                         wb_clk,
  input  logic                         wb_rst_n,
  input  logic                         i_q,
  servix_uart_monitor_if.master        mon
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t state, state_nx;

  logic          q_m, q_s, q_p;
  logic [2:0]    primed;
  logic          fall;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;
  logic          frame_err;
  logic          overflow;

  logic cnt_clr, cnt_run, shift, idx_clr, push_req, ferr_set;

  // Edge detection waits until q_p holds a real line sample.
  // This keeps a line that is low when reset is released from looking like a start bit.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      q_m    <= 1'b1;
      q_s    <= 1'b1;
      q_p    <= 1'b1;
      primed <= '0;
    end else begin
      q_m    <= i_q;
      q_s    <= q_m;
      q_p    <= q_s;
      primed <= {primed[1:0], 1'b1};
    end
  end

  assign fall = primed[2] & q_p & ~q_s;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) state <= IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (fall) state_nx = START;
      START: if (cnt == HALF) state_nx = q_s ? IDLE : DATA;
      DATA:  if (cnt == LAST && idx == 3'd7) state_nx = STOP;
      STOP:  if (cnt == LAST) state_nx = q_s ? IDLE : BRK;
      BRK:   if (q_s) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cnt_clr  = 1'b0;
    cnt_run  = 1'b0;
    shift    = 1'b0;
    idx_clr  = 1'b0;
    push_req = 1'b0;
    ferr_set = 1'b0;
    unique case (state)
      IDLE:  cnt_clr = fall;
      START: begin
        cnt_run = 1'b1;
        cnt_clr = (cnt == HALF) & ~q_s;
        idx_clr = (cnt == HALF) & ~q_s;
      end
      DATA: begin
        cnt_run = 1'b1;
        cnt_clr = (cnt == LAST);
        shift   = (cnt == LAST);
      end
      STOP: begin
        cnt_run  = 1'b1;
        push_req = (cnt == LAST) & q_s;
        ferr_set = (cnt == LAST) & ~q_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      frame_err <= 1'b0;
    end else begin
      if (cnt_clr)      cnt <= '0;
      else if (cnt_run) cnt <= cnt + 1'b1;
      if (idx_clr)      idx <= '0;
      else if (shift)   idx <= idx + 1'b1;
      if (shift)        sh  <= {q_s, sh[7:1]};
      frame_err <= ferr_set;
    end
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [LW-1:0] wp, rp;
  logic          empty, full, pop, push, drop;

  assign empty = (wp == rp);
  assign full  = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
  assign pop   = ~empty & mon.i_rdy;
  // A pop in the same cycle frees the slot the incoming byte needs.
  assign push  = push_req & (~full | pop);
  assign drop  = push_req & full & ~pop;

  always_ff @(posedge wb_clk) begin
    if (push) mem[wp[AW-1:0]] <= sh;
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wp       <= '0;
      rp       <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (drop)           overflow <= 1'b1;
      else if (mon.i_clr) overflow <= 1'b0;
    end
  end

  assign mon.o_vld       = ~empty;
  assign mon.o_rdt       = empty ? '0 : mem[rp[AW-1:0]];
  assign mon.o_level     = wp - rp;
  assign mon.o_frame_err = frame_err;
  assign mon.o_overflow  = overflow;
endmodule

// File: tb/tb_servix_uart_monitor.sv
// Drives 8N1 frames into servix_uart_monitor.
// Decoded bytes and status are compared with a queue-based model of the byte stream.
module tb_servix_uart_monitor;
  localparam int unsigned CPB   = 8;
  localparam int unsigned DEPTH = 4;

  logic wb_clk   = 1'b0;
  logic wb_rst_n = 1'b0;
  logic q        = 1'b1;
  logic rdy_hold = 1'b0;
  logic rdy_rnd  = 1'b0;
  bit   rdy_rand = 1'b0;

  servix_uart_monitor_if #(.FIFO_DEPTH(DEPTH)) bus ();

  servix_uart_monitor #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .wb_clk   (wb_clk),
    .wb_rst_n (wb_rst_n),
    .i_q      (q),
    .mon      (bus)
  );

  assign bus.i_rdy = rdy_rand ? rdy_rnd : rdy_hold;

  always #5 wb_clk = ~wb_clk;

  int checks = 0;
  int failures = 0;
  int ferr_cnt = 0;
  int vld_cycles = 0;
  logic [7:0] got[$];

  // Observe the consumer side every cycle, away from the active edge.
  always @(negedge wb_clk) begin
    rdy_rnd = 1'($urandom);
    #1;
    if (wb_rst_n) begin
      if (bus.o_vld) vld_cycles++;
      if (bus.o_vld && bus.i_rdy) got.push_back(bus.o_rdt);
      if (bus.o_frame_err) ferr_cnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge wb_clk);
      q = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit rdy_at_push = 1'b0);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < int'(CPB); c++) begin
        @(negedge wb_clk);
        q = f[i];
        if (rdy_at_push && i == 9 && c == int'(CPB) - 1) rdy_hold = 1'b1;
      end
    end
    if (rdy_at_push) begin
      @(negedge wb_clk);
      q = 1'b1;
      rdy_hold = 1'b0;
    end
  endtask

  task automatic test_reset();
    wb_rst_n = 1'b0;
    idle(3);
    #1;
    checks++; if (bus.o_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%0b exp=0", bus.o_vld); end
    checks++; if (bus.o_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", bus.o_level); end
    checks++; if (bus.o_rdt !== 8'h00) begin failures++; $display("FAIL reset_rdt got=%0h exp=0", bus.o_rdt); end
    checks++; if (bus.o_frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%0b exp=0", bus.o_frame_err); end
    checks++; if (bus.o_overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", bus.o_overflow); end
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
    idle(10);
  endtask

  task automatic test_single();
    rdy_hold = 1'b1;
    got.delete();
    vld_cycles = 0;
    ferr_cnt = 0;
    send_frame(8'h55, 1'b1);
    idle(20);
    checks++; if (got.size() !== 1) begin failures++; $display("FAIL single_count got=%0d exp=1", got.size()); end
    else begin
      checks++; if (got[0] !== 8'h55) begin failures++; $display("FAIL single_byte got=%0h exp=55", got[0]); end
    end
    checks++; if (vld_cycles !== 1) begin failures++; $display("FAIL single_vld_cycles got=%0d exp=1", vld_cycles); end
    checks++; if (bus.o_level !== 3'd0) begin failures++; $display("FAIL single_level got=%0d exp=0", bus.o_level); end
    checks++; if (ferr_cnt !== 0) begin failures++; $display("FAIL single_ferr got=%0d exp=0", ferr_cnt); end
  endtask

  task automatic test_glitch();
    rdy_hold = 1'b1;
    got.delete();
    ferr_cnt = 0;
    repeat (3) begin @(negedge wb_clk); q = 1'b0; end
    idle(30);
    checks++; if (got.size() !== 0) begin failures++; $display("FAIL glitch_bytes got=%0d exp=0", got.size()); end
    checks++; if (ferr_cnt !== 0) begin failures++; $display("FAIL glitch_ferr got=%0d exp=0", ferr_cnt); end
    send_frame(8'h3C, 1'b1);
    idle(20);
    checks++; if (got.size() !== 1 || got[0] !== 8'h3C) begin failures++;
      $display("FAIL glitch_next got_n=%0d got=%0h exp=3c", got.size(), (got.size() > 0) ? got[0] : 8'hxx); end
  endtask

  task automatic test_frame_err();
    rdy_hold = 1'b1;
    got.delete();
    ferr_cnt = 0;
    send_frame(8'hA3, 1'b0);
    repeat (40) begin @(negedge wb_clk); q = 1'b0; end
    idle(20);
    checks++; if (ferr_cnt !== 1) begin failures++; $display("FAIL ferr_pulses got=%0d exp=1", ferr_cnt); end
    checks++; if (got.size() !== 0) begin failures++; $display("FAIL ferr_push got=%0d exp=0", got.size()); end
    send_frame(8'h01, 1'b1);
    idle(20);
    checks++; if (got.size() !== 1 || got[0] !== 8'h01) begin failures++;
      $display("FAIL ferr_next got_n=%0d got=%0h exp=01", got.size(), (got.size() > 0) ? got[0] : 8'hxx); end
    checks++; if (ferr_cnt !== 1) begin failures++; $display("FAIL ferr_after got=%0d exp=1", ferr_cnt); end
  endtask

  task automatic test_back_to_back_overflow();
    logic [7:0] g;
    rdy_hold = 1'b0;
    got.delete();
    for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1'b1);
    idle(20);
    checks++; if (bus.o_level !== 3'd4) begin failures++; $display("FAIL ovf_level got=%0d exp=4", bus.o_level); end
    checks++; if (bus.o_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", bus.o_overflow); end
    checks++; if (bus.o_rdt !== 8'h10) begin failures++; $display("FAIL ovf_head got=%0h exp=10", bus.o_rdt); end
    rdy_hold = 1'b1;
    idle(8);
    rdy_hold = 1'b0;
    checks++; if (got.size() !== 4) begin failures++; $display("FAIL ovf_popcount got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      g = (i < got.size()) ? got[i] : 8'hxx;
      checks++; if (g !== 8'h10 + 8'(i)) begin failures++; $display("FAIL ovf_order[%0d] got=%0h exp=%0h", i, g, 8'h10 + 8'(i)); end
    end
    checks++; if (bus.o_level !== 3'd0) begin failures++; $display("FAIL ovf_drained got=%0d exp=0", bus.o_level); end
    @(negedge wb_clk); bus.i_clr = 1'b1;
    @(negedge wb_clk); bus.i_clr = 1'b0;
    checks++; if (bus.o_overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%0b exp=0", bus.o_overflow); end
  endtask

  task automatic test_full_with_pop();
    logic [7:0] g;
    rdy_hold = 1'b0;
    got.delete();
    for (int i = 0; i < 4; i++) send_frame(8'h20 + 8'(i), 1'b1);
    send_frame(8'h24, 1'b1, 1'b1);
    idle(5);
    checks++; if (bus.o_overflow !== 1'b0) begin failures++; $display("FAIL fullpop_ovf got=%0b exp=0", bus.o_overflow); end
    checks++; if (bus.o_level !== 3'd4) begin failures++; $display("FAIL fullpop_level got=%0d exp=4", bus.o_level); end
    checks++; if (got.size() !== 1) begin failures++; $display("FAIL fullpop_pops got=%0d exp=1", got.size()); end
    rdy_hold = 1'b1;
    idle(10);
    rdy_hold = 1'b0;
    checks++; if (got.size() !== 5) begin failures++; $display("FAIL fullpop_total got=%0d exp=5", got.size()); end
    for (int i = 0; i < 5; i++) begin
      g = (i < got.size()) ? got[i] : 8'hxx;
      checks++; if (g !== 8'h20 + 8'(i)) begin failures++; $display("FAIL fullpop_order[%0d] got=%0h exp=%0h", i, g, 8'h20 + 8'(i)); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] f;
    rdy_hold = 1'b0;
    got.delete();
    ferr_cnt = 0;
    send_frame(8'h99, 1'b1);
    idle(5);
    checks++; if (bus.o_vld !== 1'b1) begin failures++; $display("FAIL rstmid_preload got=%0b exp=1", bus.o_vld); end
    f = {1'b1, 8'hC7, 1'b0};
    for (int k = 0; k < 4 * int'(CPB) + 3; k++) begin
      @(negedge wb_clk);
      q = f[k / int'(CPB)];
    end
    @(negedge wb_clk);
    wb_rst_n = 1'b0;
    q = 1'b0;
    #1;
    checks++; if (bus.o_vld !== 1'b0) begin failures++; $display("FAIL rstmid_vld got=%0b exp=0", bus.o_vld); end
    checks++; if (bus.o_level !== 3'd0) begin failures++; $display("FAIL rstmid_level got=%0d exp=0", bus.o_level); end
    checks++; if (bus.o_rdt !== 8'h00) begin failures++; $display("FAIL rstmid_rdt got=%0h exp=0", bus.o_rdt); end
    checks++; if (bus.o_frame_err !== 1'b0) begin failures++; $display("FAIL rstmid_ferr got=%0b exp=0", bus.o_frame_err); end
    repeat (3) @(negedge wb_clk);
    wb_rst_n = 1'b1;
    repeat (30) begin @(negedge wb_clk); q = 1'b0; end
    idle(20);
    checks++; if (bus.o_level !== 3'd0) begin failures++; $display("FAIL rstmid_lowline level got=%0d exp=0", bus.o_level); end
    checks++; if (ferr_cnt !== 0) begin failures++; $display("FAIL rstmid_lowline ferr got=%0d exp=0", ferr_cnt); end
    rdy_hold = 1'b1;
    send_frame(8'hC7, 1'b1);
    idle(20);
    checks++; if (got.size() !== 1 || got[0] !== 8'hC7) begin failures++;
      $display("FAIL rstmid_next got_n=%0d got=%0h exp=c7", got.size(), (got.size() > 0) ? got[0] : 8'hxx); end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b, g;
    int nbad;
    bit bad;
    got.delete();
    ferr_cnt = 0;
    nbad = 0;
    rdy_rand = 1'b1;
    for (int n = 0; n < 24; n++) begin
      b = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      send_frame(b, !bad);
      if (bad) nbad++;
      else     exp_q.push_back(b);
      idle(bad ? $urandom_range(4, 12) : $urandom_range(0, 12));
    end
    idle(40);
    rdy_rand = 1'b0;
    rdy_hold = 1'b0;
    idle(2);
    checks++; if (got.size() !== exp_q.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got.size()) ? got[i] : 8'hxx;
      checks++; if (g !== exp_q[i]) begin failures++; $display("FAIL rand_byte[%0d] got=%0h exp=%0h", i, g, exp_q[i]); end
    end
    checks++; if (ferr_cnt !== nbad) begin failures++; $display("FAIL rand_ferr got=%0d exp=%0d", ferr_cnt, nbad); end
    checks++; if (bus.o_overflow !== 1'b0) begin failures++; $display("FAIL rand_ovf got=%0b exp=0", bus.o_overflow); end
    checks++; if (bus.o_level !== 3'd0) begin failures++; $display("FAIL rand_level got=%0d exp=0", bus.o_level); end
  endtask

  initial begin
    bus.i_clr = 1'b0;
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_back_to_back_overflow();
    test_full_with_pop();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
